// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a valid/ready handshake on the input and output sides.
// Only one operation is in flight at a time. Single-cycle ops produce their result
// one cycle after accept.
// Optional macro ALU_SEQ_MUL_EN adds a multi-cycle shift-add multiplier for opcode 11.
// Without that macro, opcode 11 is treated as illegal.
module alu_seq #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             err
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_EQ   = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;

  // WIDTH always fits in SHAMT_W bits, so the shift-range test stays at the shift width.
  localparam logic [SHAMT_W-1:0] L_SH_LIMIT = SHAMT_W'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                     w_accept;
  logic                     w_is_mul;
  logic [WIDTH-1:0]         w_res;
  logic                     w_c;
  logic                     w_v;
  logic                     w_err;
  logic [WIDTH:0]           w_sum;
  logic [WIDTH-1:0]         w_diff;
  logic signed [WIDTH-1:0]  w_a_s;
  logic signed [WIDTH-1:0]  w_b_s;
  logic [SHAMT_W-1:0]       w_shamt;

  logic [WIDTH-1:0]         r_result;
  logic                     r_flag_z;
  logic                     r_flag_n;
  logic                     r_flag_c;
  logic                     r_flag_v;
  logic                     r_err;

  // Amounts of WIDTH or more shift every bit out.
  function automatic logic [WIDTH-1:0] f_shl(input logic [WIDTH-1:0] v,
                                             input logic [SHAMT_W-1:0] n);
    if (n >= L_SH_LIMIT) return '0;
    return v << n;
  endfunction

  function automatic logic [WIDTH-1:0] f_shr(input logic [WIDTH-1:0] v,
                                             input logic [SHAMT_W-1:0] n);
    if (n >= L_SH_LIMIT) return '0;
    return v >> n;
  endfunction

  // An over-range arithmetic shift leaves only copies of the sign bit.
  function automatic logic [WIDTH-1:0] f_sra(input logic signed [WIDTH-1:0] v,
                                             input logic [SHAMT_W-1:0] n);
    if (n >= L_SH_LIMIT) return {WIDTH{v[WIDTH-1]}};
    return v >>> n;
  endfunction

  assign w_sum     = {1'b0, a} + {1'b0, b};
  assign w_diff    = a - b;
  assign w_a_s     = a;
  assign w_b_s     = b;
  assign w_shamt   = b[SHAMT_W-1:0];
  assign in_ready  = ~rst & ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready));
  assign w_accept  = in_valid & in_ready;
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign flag_z    = r_flag_z;
  assign flag_n    = r_flag_n;
  assign flag_c    = r_flag_c;
  assign flag_v    = r_flag_v;
  assign err       = r_err;

`ifdef ALU_SEQ_MUL_EN
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_mul_last;

  // The partial sum including this cycle's step; on the last step this is the full product.
  assign w_prod     = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_last = (r_state == S_BUSY) && (r_cnt == CNT_W'(1));

  // Step counter: loaded on a MUL accept; BUSY ends when the counter reaches 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_accept && w_is_mul) begin
      r_cnt <= CNT_W'(WIDTH);
    end else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Shift-add datapath: add the multiplicand when the current multiplier LSB is set.
  always_ff @(posedge clk) begin
    if (w_accept && w_is_mul) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
    end else if (r_state == S_BUSY) begin
      r_acc    <= w_prod;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end
`endif

  // Single-cycle result and flag selection for the operation being offered.
  always_comb begin
    w_res    = '0;
    w_c      = 1'b0;
    w_v      = 1'b0;
    w_err    = 1'b0;
    w_is_mul = 1'b0;
    case (op)
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_diff;
        w_c   = (a < b);
        w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_XOR:  w_res = a ^ b;
      OP_SHL:  w_res = f_shl(a, w_shamt);
      OP_SHR:  w_res = f_shr(a, w_shamt);
      OP_EQ:   w_res = {{(WIDTH-1){1'b0}}, (a == b)};
      OP_SRA:  w_res = f_sra(w_a_s, w_shamt);
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, (w_a_s < w_b_s)};
      OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (a < b)};
`ifdef ALU_SEQ_MUL_EN
      OP_MUL:  w_is_mul = 1'b1;
`else
      OP_MUL:  w_err = 1'b1;
`endif
      default: w_err = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: a DONE slot can hand straight over to a new op without a bubble.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = w_is_mul ? S_BUSY : S_DONE;
      end
`ifdef ALU_SEQ_MUL_EN
      S_BUSY: begin
        if (w_mul_last) w_state_nxt = S_DONE;
      end
`endif
      S_DONE: begin
        if (w_accept)       w_state_nxt = w_is_mul ? S_BUSY : S_DONE;
        else if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output register: loaded on a single-cycle accept or on the final multiply step, else held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_flag_z <= 1'b0;
      r_flag_n <= 1'b0;
      r_flag_c <= 1'b0;
      r_flag_v <= 1'b0;
      r_err    <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      r_result <= w_res;
      r_flag_z <= (w_res == '0);
      r_flag_n <= w_res[WIDTH-1];
      r_flag_c <= w_c;
      r_flag_v <= w_v;
      r_err    <= w_err;
    end
`ifdef ALU_SEQ_MUL_EN
    else if (w_mul_last) begin
      r_result <= w_prod[WIDTH-1:0];
      r_flag_z <= (w_prod[WIDTH-1:0] == '0);
      r_flag_n <= w_prod[WIDTH-1];
      r_flag_c <= |w_prod[2*WIDTH-1:WIDTH];
      r_flag_v <= 1'b0;
      r_err    <= 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=16). Expected results come from a reference
// model and go into a scoreboard queue at accept. They are compared when the result is
// taken by the consumer. Directed tasks add their own inline checks.
module tb_alu_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         flag_z;
  logic         flag_n;
  logic         flag_c;
  logic         flag_v;
  logic         err;

  int n_err = 0;
  int n_chk = 0;

  // Packed as {err, v, c, n, z, result}.
  logic [W+4:0] exp_q[$];
  logic [W+4:0] mon_got;
  logic [W+4:0] mon_exp;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
    .flag_v(flag_v), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [W+4:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                         input logic [3:0] mop);
    longint unsigned ua  = 64'(ma);
    longint unsigned ub  = 64'(mb);
    longint          sa  = longint'($signed(ma));
    longint          sbv = longint'($signed(mb));
    longint unsigned t   = 0;
    longint          st  = 0;
    int              sh  = int'(mb[4:0]);
    logic [15:0]     r   = '0;
    logic            c   = 1'b0;
    logic            v   = 1'b0;
    logic            e   = 1'b0;
    case (mop)
      4'd0: begin t = ua + ub; r = t[15:0]; c = t[16]; st = sa + sbv; v = (st > 32767) || (st < -32768); end
      4'd1: begin t = ua - ub; r = t[15:0]; c = (ua < ub); st = sa - sbv; v = (st > 32767) || (st < -32768); end
      4'd2: r = ma & mb;
      4'd3: r = ma | mb;
      4'd4: r = ma ^ mb;
      4'd5: begin t = ua << sh; r = t[15:0]; end
      4'd6: begin t = ua >> sh; r = t[15:0]; end
      4'd7: r = {15'd0, (ma == mb)};
      4'd8: begin st = sa >>> sh; r = st[15:0]; end
      4'd9: r = {15'd0, (sa < sbv)};
      4'd10: r = {15'd0, (ua < ub)};
`ifdef ALU_SEQ_MUL_EN
      4'd11: begin t = ua * ub; r = t[15:0]; c = (t[31:16] != 16'd0); end
`endif
      default: e = 1'b1;
    endcase
    return {e, v, c, r[15], (r == 16'd0), r};
  endfunction

  // Scoreboard: retire the delivered result first, then record a newly accepted op.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        n_chk++;
        mon_got = {err, flag_v, flag_c, flag_n, flag_z, result};
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected: got %h with no pending op", mon_got);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_got !== mon_exp) begin
            n_err++;
            $display("FAIL sb_result: got {e,v,c,n,z,res}=%h expected %h", mon_got, mon_exp);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, op));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Offer one op and return at posedge+1 just after the accepting edge.
  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic [3:0] iop);
    int k;
    a = ia; b = ib; op = iop; in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      n_chk++; n_err++;
      $display("FAIL issue_timeout: in_ready=%b required 1 within 60 cycles", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    n_chk++;
    if ({out_valid, err, flag_v, flag_c, flag_n, flag_z, result} !== 22'd0) begin
      n_err++;
      $display("FAIL reset_state: got valid=%b e=%b v=%b c=%b n=%b z=%b res=%h required all 0",
               out_valid, err, flag_v, flag_c, flag_n, flag_z, result);
    end
    n_chk++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    issue(16'hFFFF, 16'h0001, 4'd0);
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL add_latency: out_valid=%b required 1", out_valid); end
    n_chk++;
    if ({err, flag_v, flag_c, flag_n, flag_z, result} !== {5'b00101, 16'h0000}) begin
      n_err++;
      $display("FAIL add_wrap: got e=%b v=%b c=%b n=%b z=%b res=%h required e0 v0 c1 n0 z1 0000",
               err, flag_v, flag_c, flag_n, flag_z, result);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL add_to_idle: out_valid=%b required 0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_sub_slt();
    issue(16'h8000, 16'h0001, 4'd1);
    @(negedge clk);
    n_chk++;
    if ({result, flag_v, flag_c, flag_n} !== {16'h7FFF, 3'b100}) begin
      n_err++;
      $display("FAIL sub_ovf: got res=%h v=%b c=%b n=%b required 7fff v1 c0 n0", result, flag_v, flag_c, flag_n);
    end
    @(posedge clk); #1;
    issue(16'h8000, 16'h0001, 4'd9);
    @(negedge clk);
    n_chk++;
    if (result !== 16'h0001) begin n_err++; $display("FAIL slt: got %h required 0001", result); end
    @(posedge clk); #1;
    issue(16'h8000, 16'h0001, 4'd10);
    @(negedge clk);
    n_chk++;
    if (result !== 16'h0000) begin n_err++; $display("FAIL sltu: got %h required 0000", result); end
    @(posedge clk); #1;
  endtask

  task automatic test_shift();
    issue(16'h0001, 16'd16, 4'd5);
    @(negedge clk);
    n_chk++;
    if ({result, flag_z} !== {16'h0000, 1'b1}) begin n_err++; $display("FAIL shl_over: got %h z=%b required 0000 z1", result, flag_z); end
    @(posedge clk); #1;
    issue(16'h8000, 16'd20, 4'd8);
    @(negedge clk);
    n_chk++;
    if ({result, flag_n} !== {16'hFFFF, 1'b1}) begin n_err++; $display("FAIL sra_over: got %h n=%b required ffff n1", result, flag_n); end
    @(posedge clk); #1;
    issue(16'h8000, 16'd15, 4'd6);
    @(negedge clk);
    n_chk++;
    if (result !== 16'h0001) begin n_err++; $display("FAIL shr: got %h required 0001", result); end
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
`ifdef ALU_SEQ_MUL_EN
    logic busy_ok;
    int   k;
    issue(16'h0100, 16'h0100, 4'd11);
    // Changing operands while BUSY has no effect.
    a = 16'hFFFF; b = 16'hFFFF; op = 4'd0;
    busy_ok = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || out_valid !== 1'b0) busy_ok = 1'b0;
      @(posedge clk); #1;
    end
    n_chk++;
    if (busy_ok !== 1'b1) begin n_err++; $display("FAIL mul_busy: in_ready/out_valid not 0 for 16 cycles (got %b required 1)", busy_ok); end
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL mul_latency: out_valid=%b required 1 at cycle 17", out_valid); end
    n_chk++;
    if ({err, flag_v, flag_c, flag_n, flag_z, result} !== {5'b00101, 16'h0000}) begin
      n_err++;
      $display("FAIL mul_hi: got e=%b v=%b c=%b n=%b z=%b res=%h required c1 z1 0000",
               err, flag_v, flag_c, flag_n, flag_z, result);
    end
    @(posedge clk); #1;
    issue(16'h1234, 16'h0011, 4'd11);
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    if ({out_valid, result, flag_c} !== {1'b1, 16'h3574, 1'b1}) begin
      n_err++;
      $display("FAIL mul_val: got valid=%b res=%h c=%b required 1 3574 c1", out_valid, result, flag_c);
    end
    @(posedge clk); #1;
`else
    issue(16'h0100, 16'h0100, 4'd11);
    @(negedge clk);
    n_chk++;
    if ({out_valid, err, result} !== {2'b11, 16'h0000}) begin
      n_err++;
      $display("FAIL mul_disabled: got valid=%b err=%b res=%h required 1 1 0000", out_valid, err, result);
    end
    @(posedge clk); #1;
`endif
  endtask

  task automatic test_back_to_back();
    logic [W+4:0] held;
    logic         stable_ok;
    logic         stream_ok;
    out_ready = 1'b0;
    issue(16'h1111, 16'h2222, 4'd0);
    @(negedge clk);
    held = {err, flag_v, flag_c, flag_n, flag_z, result};
    n_chk++;
    if ({out_valid, held} !== {1'b1, 5'b00000, 16'h3333}) begin
      n_err++;
      $display("FAIL hold_first: got valid=%b %h required 1 3333", out_valid, held);
    end
    @(posedge clk); #1;
    // Offered during the stall; must not be accepted until out_ready rises.
    a = 16'h0100; b = 16'h0001; op = 4'd0; in_valid = 1'b1;
    stable_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          {err, flag_v, flag_c, flag_n, flag_z, result} !== held) stable_ok = 1'b0;
      @(posedge clk); #1;
    end
    n_chk++;
    if (stable_ok !== 1'b1) begin n_err++; $display("FAIL hold_stable: outputs changed or in_ready high (got %b required 1)", stable_ok); end
    out_ready = 1'b1;
    stream_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (in_ready !== 1'b1 || out_valid !== 1'b1) stream_ok = 1'b0;
      @(posedge clk); #1;
      if (k < 3) begin
        a = 16'h0100 * 16'(k + 2);
        b = 16'(k + 2);
      end else begin
        in_valid = 1'b0;
      end
    end
    n_chk++;
    if (stream_ok !== 1'b1) begin n_err++; $display("FAIL stream: gap in back-to-back flow (got %b required 1)", stream_ok); end
    @(negedge clk);
    n_chk++;
    if ({out_valid, result} !== {1'b1, 16'h0404}) begin
      n_err++;
      $display("FAIL stream_last: got valid=%b res=%h required 1 0404", out_valid, result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    issue(16'h1234, 16'h5678, 4'hD);
    @(negedge clk);
    n_chk++;
    if ({err, flag_z, flag_c, flag_v, flag_n, result} !== {5'b11000, 16'h0000}) begin
      n_err++;
      $display("FAIL illegal: got err=%b z=%b c=%b v=%b n=%b res=%h required err1 z1 0000",
               err, flag_z, flag_c, flag_v, flag_n, result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic quiet_ok;
`ifdef ALU_SEQ_MUL_EN
    out_ready = 1'b1;
    issue(16'h0003, 16'h0005, 4'd11);
    repeat (4) @(posedge clk);
    #1;
`else
    out_ready = 1'b0;
    issue(16'h0003, 16'h0005, 4'd0);
`endif
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_mid_in_ready: got %b required 0", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    exp_q.delete();
    @(negedge clk);
    n_chk++;
    if ({out_valid, in_ready, result} !== {2'b01, 16'h0000}) begin
      n_err++;
      $display("FAIL rst_mid_state: got valid=%b in_ready=%b res=%h required 0 1 0000", out_valid, in_ready, result);
    end
    @(posedge clk); #1;
    quiet_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) quiet_ok = 1'b0;
      @(posedge clk); #1;
    end
    n_chk++;
    if (quiet_ok !== 1'b1) begin n_err++; $display("FAIL rst_mid_stale: stale result presented (got %b required 1)", quiet_ok); end
    issue(16'h0002, 16'h0003, 4'd0);
    @(negedge clk);
    n_chk++;
    if ({out_valid, result} !== {1'b1, 16'h0005}) begin
      n_err++;
      $display("FAIL rst_mid_add: got valid=%b res=%h required 1 0005", out_valid, result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int k;
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a  = 16'($urandom);
      b  = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 31)) : 16'($urandom);
      op = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    n_chk++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL random_drain: %0d results outstanding, required 0", exp_q.size()); end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0; b = '0; op = '0;
    test_reset();
    test_add();
    test_sub_slt();
    test_shift();
    test_mul();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    test_random();
    n_chk++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL final_queue: %0d left, required 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 4-bit combinational ALU.
- Adds WIDTH generalisation, an extended opcode set, status flags, and a valid/ready handshake on both sides.
- Adds an optional multi-cycle shift-add multiplier.
- Sits between the operand/decode stage and the writeback stage of the datapath; one operation in flight at a time.

Parameters:
- WIDTH, 16, operand/result width in bits; minimum 2.
- SHAMT_W, $clog2(WIDTH)+1, bits of b examined as the shift amount.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and op are presented.
- in_ready  output  1  block can accept an operation this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; also the shift amount.
- op  input  4  opcode.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  registered result.
- flag_z  output  1  result == 0.
- flag_n  output  1  result[WIDTH-1].
- flag_c  output  1  carry/borrow/high-half indication.
- flag_v  output  1  signed overflow.
- err  output  1  illegal or disabled opcode.

Behaviour:
- One clock, synchronous active-high reset; clock port clk, reset port rst.
- Reset values: state IDLE, out_valid=0, result=0, all flags=0, err=0.
- in_ready is forced to 0 while rst=1. Reset mid-multiply aborts the operation; no stale result is ever presented.
- States:
  - IDLE: out_valid=0.
  - BUSY: multiply in progress.
  - DONE: out_valid=1; result and flags held stable.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This permits back-to-back operations.
- An accept occurs when in_valid && in_ready.
- Transitions:
  - Single-cycle op accepted: result registered on that edge, next state DONE. out_valid is high the cycle after accept (latency 1).
  - MUL accepted: next state BUSY; counter loaded to WIDTH.
  - BUSY: one shift-add step per cycle; counter decrements; at counter==1 next state DONE. out_valid rises WIDTH+1 cycles after accept. in_ready=0 throughout BUSY.
  - DONE with out_ready=1 and no new accept: next state IDLE.
  - DONE with out_ready=1 and a simultaneous accept: the new op enters DONE or BUSY directly; there is no bubble.
  - DONE with out_ready=0: all outputs held unchanged.
- Opcodes:
  - 0 ADD, 1 SUB (a-b), 2 AND, 3 OR, 4 XOR.
  - 5 SHL, 6 SHR (logical), 7 EQ (result = {0…,a==b}).
  - 8 SRA (arithmetic right).
  - 9 SLT (signed a<b, result 0/1), 10 SLTU (unsigned a<b, result 0/1).
  - 11 MUL (low WIDTH bits of the unsigned product).
  - 12–15 illegal.
- Shifts: amount is b[SHAMT_W-1:0].
  - If the amount ≥ WIDTH: SHL/SHR give 0; SRA gives all bits equal to a[WIDTH-1].
- Flags:
  - flag_z and flag_n are computed from the final result for every op.
  - ADD: flag_c = carry out of bit WIDTH-1; flag_v = signed overflow.
  - SUB: flag_c = borrow (a<b unsigned); flag_v = signed overflow.
  - MUL: flag_c = 1 when the upper WIDTH bits of the full product are nonzero; flag_v=0.
  - All other ops: flag_c=0, flag_v=0.
- Illegal opcodes complete in 1 cycle with result=0, flag_z=1, other flags 0, err=1.
- err=0 for all legal ops.
- Arithmetic wraps modulo 2^WIDTH.
- Inputs are sampled only at accept; changing a, b or op during BUSY has no effect.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: opcode 11 performs the multi-cycle multiply described above. BUSY state, counter and partial-product register are present.
- Undefined: no multiplier logic. Opcode 11 is treated as illegal (1-cycle, result=0, err=1). BUSY is never entered.

Test Plan:
- ADD a=0xFFFF b=0x0001 → next cycle out_valid=1, result=0x0000, z=1, c=1, v=0, err=0.
- SUB a=0x8000 b=0x0001 → result=0x7FFF, v=1, c=0, n=0. Then SLT a=0x8000 b=0x0001 → result=1, and SLTU with the same operands → result=0.
- SHL a=0x0001 b=16 → 0x0000, z=1. SRA a=0x8000 b=20 → 0xFFFF, n=1. SHR a=0x8000 b=15 → 0x0001.
- With ALU_SEQ_MUL_EN: MUL a=0x0100 b=0x0100 → in_ready=0 for 16 cycles; out_valid exactly 17 cycles after accept; result=0x0000, c=1, z=1. Without the macro: the same stimulus → 1-cycle result 0x0000, err=1.
- Handshake:
  - Hold out_ready=0 for 5 cycles after an ADD: result, flags and out_valid stay stable, and in_ready=0.
  - Then stream 4 ADDs with out_ready=1 and in_valid=1: one result per cycle, in order.
  - Opcode 4'hD → err=1, result=0.
- Assert rst for one cycle at BUSY cycle 5 of a MUL → the following cycle shows out_valid=0, in_ready=1, result=0. A subsequent ADD 2+3 → result=0x0005.
